// File: rtl/unpacker_pkg.sv
// unpacker_pkg
//   Shared definitions for the bit unpacker: state encoding and the helper
//   functions that size the bit buffer and its counters.
package unpacker_pkg;

    typedef enum logic {
        FILL  = 1'b0,   // accepting packed words
        DRAIN = 1'b1    // last word buffered, only field requests served
    } unp_state_e;

    // Bit-buffer width: one full input word plus one maximum-size field.
    function automatic int unp_buf_w(input int bus_w, input int max_out_w);
        return bus_w + max_out_w;
    endfunction

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int unp_cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_window_extract.sv
// bit_window_extract
//   Combinational MSB window select: returns the top num_bits bits of vec,
//   right-justified in window with zero upper bits.  Equivalent to
//   vec >> (IN_W - num_bits), truncated to OUT_W.  With OUT_W == IN_W it
//   doubles as a right shifter by (IN_W - num_bits), which the unpacker
//   uses to place an incoming word just below the surviving buffer bits.
// Ports
//   vec       in   IN_W   source vector, MSB first
//   num_bits  in   N_W    window width (0..IN_W)
//   window    out  OUT_W  selected bits, right-justified
module bit_window_extract #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int N_W   = 5
) (
    input  logic [IN_W-1:0]  vec,
    input  logic [N_W-1:0]   num_bits,
    output logic [OUT_W-1:0] window
);

    logic [31:0] shamt;

    always_comb begin
        // num_bits == 0 shifts by the full width, giving an all-zero window.
        shamt  = 32'(IN_W) - 32'(num_bits);
        window = OUT_W'(vec >> shamt);
    end

endmodule

// File: rtl/bit_unpacker.sv
// bit_unpacker
//   Splits a packed MSB-first bitstream, delivered as BUS_WIDTH-bit words,
//   into variable-length fields of up to MAX_OUT_WIDTH bits on request.
//   Valid bits are kept MSB-aligned in a BUF_W-bit buffer; bits below the
//   fill level are always zero, so an underflow read zero-fills naturally.
//
//   Optional feature macro: UNPACKER_ERR_EN
//     defined   - a DRAIN-state request for more bits than buffered returns
//                 the remaining bits zero-filled, empties the buffer, goes
//                 back to FILL and sets the sticky err_underflow flag.
//     undefined - such a request stalls (out_valid=0) until reset;
//                 err_underflow is tied 0.
//
// Ports
//   clk            in   1        clock
//   reset          in   1        synchronous, active-high reset
//   in_valid       in   1        input word valid
//   in_ready       out  1        word accepted when in_valid && in_ready
//   in_data        in   BUS_W    packed word, [BUS_WIDTH-1] is first bit
//   in_last        in   1        final (zero-padded) word of the stream
//   req_valid      in   1        field request, also ready for out_*
//   req_num_bits   in   NB_W     requested width n (clamped to MAX_OUT)
//   out_valid      out  1        field available (combinational)
//   out_data       out  MAX_OUT  field right-justified, upper bits zero
//   bits_left      out  FILL_W   buffered bit count
//   stream_end     out  1        last word buffered (DRAIN state)
//   err_underflow  out  1        sticky underflow flag
module bit_unpacker
    import unpacker_pkg::*;
#(
    parameter int BUS_WIDTH     = 8,
    parameter int MAX_OUT_WIDTH = 8,
    localparam int BUF_W  = unp_buf_w(BUS_WIDTH, MAX_OUT_WIDTH),
    localparam int NB_W   = unp_cnt_w(MAX_OUT_WIDTH),
    localparam int FILL_W = unp_cnt_w(BUF_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BUS_WIDTH-1:0]     in_data,
    input  logic                     in_last,
    input  logic                     req_valid,
    input  logic [NB_W-1:0]          req_num_bits,
    output logic                     out_valid,
    output logic [MAX_OUT_WIDTH-1:0] out_data,
    output logic [FILL_W-1:0]        bits_left,
    output logic                     stream_end,
    output logic                     err_underflow
);

    logic [BUF_W-1:0]  bit_buf, buf_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    unp_state_e        state, state_nxt;

    logic [NB_W-1:0]   n_clamp;
    logic [FILL_W-1:0] n_ext;
    logic              fits;
    logic              underflow;
    logic              load;
    logic [FILL_W-1:0] consumed;
    logic [FILL_W-1:0] keep;
    logic [FILL_W-1:0] place_n;
    logic [BUF_W-1:0]  word_placed;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    always_comb begin
        n_clamp = (req_num_bits > NB_W'(MAX_OUT_WIDTH)) ? NB_W'(MAX_OUT_WIDTH)
                                                        : req_num_bits;
        n_ext   = FILL_W'(n_clamp);
        fits    = (n_ext <= fill);
    end

`ifdef UNPACKER_ERR_EN
    assign underflow = !reset && req_valid && (state == DRAIN) && !fits;
`else
    assign underflow = 1'b0;
`endif

    // in_ready looks only at registered state: a consume in the same cycle
    // does not make room early.
    assign in_ready  = !reset && (state == FILL) &&
                       ((FILL_W'(BUF_W) - fill) >= FILL_W'(BUS_WIDTH));
    assign out_valid = !reset && req_valid && (fits || underflow);
    assign load      = in_valid && in_ready;

    // Field select straight from the buffer top: zero-latency output.
    bit_window_extract #(
        .IN_W  (BUF_W),
        .OUT_W (MAX_OUT_WIDTH),
        .N_W   (NB_W)
    ) u_field (
        .vec      (bit_buf),
        .num_bits (n_clamp),
        .window   (out_data)
    );

    // ---------------------------------------------------------------
    // Load position: an accepted word lands right below the bits that
    // survive this cycle's consume, i.e. {in_data, 0} >> keep.
    // ---------------------------------------------------------------
    always_comb begin
        consumed = (out_valid && fits) ? n_ext : '0;
        keep     = fill - consumed;
        place_n  = FILL_W'(BUF_W) - keep;
    end

    bit_window_extract #(
        .IN_W  (BUF_W),
        .OUT_W (BUF_W),
        .N_W   (FILL_W)
    ) u_place (
        .vec      ({in_data, {MAX_OUT_WIDTH{1'b0}}}),
        .num_bits (place_n),
        .window   (word_placed)
    );

    // ---------------------------------------------------------------
    // Next-state
    // ---------------------------------------------------------------
    always_comb begin
        buf_nxt   = (bit_buf << consumed) | (load ? word_placed : '0);
        fill_nxt  = keep + (load ? FILL_W'(BUS_WIDTH) : '0);
        state_nxt = state;
        if (load && in_last)
            state_nxt = DRAIN;
        if (underflow) begin
            // Flush: remaining bits were just emitted, start a new stream.
            buf_nxt   = '0;
            fill_nxt  = '0;
            state_nxt = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_buf <= '0;
            fill    <= '0;
            state   <= FILL;
        end else begin
            bit_buf <= buf_nxt;
            fill    <= fill_nxt;
            state   <= state_nxt;
        end
    end

`ifdef UNPACKER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (underflow)
            err_q <= 1'b1;
    end

    assign err_underflow = err_q;
`else
    assign err_underflow = 1'b0;
`endif

    assign bits_left  = fill;
    assign stream_end = (state == DRAIN);

endmodule

// File: tb/tb_bit_unpacker.sv
module tb_bit_unpacker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       req_valid;
    logic [3:0] req_num_bits;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] bits_left;
    logic       stream_end, err_underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_unpacker #(.BUS_WIDTH(8), .MAX_OUT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .req_valid     (req_valid),
        .req_num_bits  (req_num_bits),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .bits_left     (bits_left),
        .stream_end    (stream_end),
        .err_underflow (err_underflow)
    );

    // Inputs change at posedge+1, outputs are sampled at negedge.
    task automatic idle();
        in_valid = 0; in_data = 0; in_last = 0;
        req_valid = 0; req_num_bits = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic push_word(input logic [7:0] d, input logic l);
        int t = 0;
        in_valid = 1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout word=%h in_ready stayed 0", d);
        end
        @(posedge clk); #1;
        in_valid = 0; in_data = 0; in_last = 0;
    endtask

    task automatic pull(input logic [3:0] n, output logic v, output logic [7:0] d);
        req_valid = 1; req_num_bits = n;
        @(negedge clk);
        v = out_valid; d = out_data;
        @(posedge clk); #1;
        req_valid = 0; req_num_bits = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; in_valid = 1; req_valid = 1; req_num_bits = 0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        idle(); reset = 0;
        req_valid = 1; req_num_bits = 3;
        @(negedge clk);
        checks++; if (bits_left !== 5'd0) begin failures++; $display("FAIL rst_fill got=%0d exp=0", bits_left); end
        checks++; if (stream_end !== 1'b0) begin failures++; $display("FAIL rst_stream_end got=%b exp=0", stream_end); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_underflow); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_stall got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_stream();
        logic [7:0] words [4];
        int wi = 0, ri = 0, cyc = 0;
        words[0] = 8'hCF; words[1] = 8'h3C; words[2] = 8'hF3; words[3] = 8'hCC;
        do_reset();
        while ((wi < 4 || ri < 5) && cyc < 60) begin
            in_valid = (wi < 4); in_data = words[wi & 3]; in_last = (wi == 3);
            req_valid = (ri < 5); req_num_bits = 4'd6;
            @(negedge clk);
            if (req_valid && out_valid) begin
                checks++;
                if (out_data !== 8'h33) begin failures++; $display("FAIL stream_field%0d got=%h exp=33", ri, out_data); end
                ri++;
            end
            if (in_valid && in_ready) wi++;
            @(posedge clk); #1;
            cyc++;
        end
        idle();
        checks++; if (ri != 5 || wi != 4) begin failures++; $display("FAIL stream_timeout fields=%0d words=%0d exp=5/4", ri, wi); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd2) begin failures++; $display("FAIL stream_left got=%0d exp=2", bits_left); end
        checks++; if (stream_end !== 1'b1) begin failures++; $display("FAIL stream_end got=%b exp=1", stream_end); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL drain_in_ready got=%b exp=0", in_ready); end
    endtask

    task automatic test_fill_levels();
        logic v; logic [7:0] d;
        do_reset();
        push_word(8'hAB, 0);
        push_word(8'hCD, 0);
        @(negedge clk);
        checks++; if (bits_left !== 5'd16) begin failures++; $display("FAIL full_fill got=%0d exp=16", bits_left); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        pull(4'd3, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h05) begin failures++; $display("FAIL req3 got=%b/%h exp=1/05", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd13 || in_ready !== 1'b0) begin failures++; $display("FAIL fill13 got=%0d/%b exp=13/0", bits_left, in_ready); end
        @(posedge clk); #1;
        pull(4'd5, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h0B) begin failures++; $display("FAIL req5 got=%b/%h exp=1/0b", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd8 || in_ready !== 1'b1) begin failures++; $display("FAIL fill8 got=%0d/%b exp=8/1", bits_left, in_ready); end
        @(posedge clk); #1;
        pull(4'd15, v, d);
        checks++; if (v !== 1'b1 || d !== 8'hCD) begin failures++; $display("FAIL clamp got=%b/%h exp=1/cd", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd0) begin failures++; $display("FAIL clamp_fill got=%0d exp=0", bits_left); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic v; logic [7:0] d;
        do_reset();
        push_word(8'hA5, 0);
        in_valid = 1; in_data = 8'h3C; req_valid = 1; req_num_bits = 4'd8;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin failures++; $display("FAIL b2b_out got=%b/%h exp=1/a5", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++; if (bits_left !== 5'd8) begin failures++; $display("FAIL b2b_fill got=%0d exp=8", bits_left); end
        @(posedge clk); #1;
        pull(4'd8, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h3C) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/3c", v, d); end
    endtask

    task automatic test_zero_req();
        logic v; logic [7:0] d;
        do_reset();
        pull(4'd0, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL zero_empty got=%b/%h exp=1/00", v, d); end
        push_word(8'hFF, 0);
        pull(4'd0, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL zero_full got=%b/%h exp=1/00", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd8) begin failures++; $display("FAIL zero_fill got=%0d exp=8", bits_left); end
        @(posedge clk); #1;
    endtask

    task automatic test_underflow();
        logic v; logic [7:0] d;
        do_reset();
        push_word(8'h05, 1);
        pull(4'd5, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL uf_pre got=%b/%h exp=1/00", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd3 || stream_end !== 1'b1) begin failures++; $display("FAIL uf_state got=%0d/%b exp=3/1", bits_left, stream_end); end
        @(posedge clk); #1;
`ifdef UNPACKER_ERR_EN
        pull(4'd5, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h14) begin failures++; $display("FAIL uf_out got=%b/%h exp=1/14", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd0 || err_underflow !== 1'b1) begin failures++; $display("FAIL uf_after got=%0d/%b exp=0/1", bits_left, err_underflow); end
        checks++; if (stream_end !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL uf_refill got=%b/%b exp=0/1", stream_end, in_ready); end
        @(posedge clk); #1;
        push_word(8'h11, 0);
        @(negedge clk);
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
        @(posedge clk); #1;
`else
        req_valid = 1; req_num_bits = 4'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL uf_stall%0d got=%b exp=0", i, out_valid); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (bits_left !== 5'd3 || err_underflow !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL uf_hold got=%0d/%b/%b exp=3/0/0", bits_left, err_underflow, in_ready); end
        @(posedge clk); #1;
        idle();
`endif
    endtask

    task automatic test_reset_mid();
        logic v; logic [7:0] d;
        do_reset();
        push_word(8'h12, 0);
        push_word(8'h34, 1);
        pull(4'd5, v, d);
        checks++; if (v !== 1'b1 || d !== 8'h02) begin failures++; $display("FAIL mid_field got=%b/%h exp=1/02", v, d); end
        @(negedge clk);
        checks++; if (bits_left !== 5'd11 || stream_end !== 1'b1) begin failures++; $display("FAIL mid_state got=%0d/%b exp=11/1", bits_left, stream_end); end
        @(posedge clk); #1;
        reset = 1; req_valid = 1; req_num_bits = 4'd4;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_reset got=%b/%b exp=0/0", out_valid, in_ready); end
        @(posedge clk); #1;
        reset = 0; idle();
        @(negedge clk);
        checks++; if (bits_left !== 5'd0 || stream_end !== 1'b0) begin failures++; $display("FAIL mid_release got=%0d/%b exp=0/0", bits_left, stream_end); end
        checks++; if (in_ready !== 1'b1 || err_underflow !== 1'b0) begin failures++; $display("FAIL mid_release_rdy got=%b/%b exp=1/0", in_ready, err_underflow); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_levels();
        test_back_to_back();
        test_zero_req();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
